// File: rtl/bp_pkg.sv
// Shared types and helpers for the branch predictor slice.
// No timing of its own: FSM state encoding and counter reset value only.
package bp_pkg;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } bp_state_t;

  // Weakly not-taken: one below the taken threshold.
  function automatic int unsigned cnt_reset_val(input int unsigned cnt_w);
    return (32'd1 << (cnt_w - 1)) - 32'd1;
  endfunction

endpackage

// File: rtl/bp_table.sv
// Saturating counter array plus tagged BTB, one async read port, one trained write port, one clear port.
// Read is combinational; writes land at posedge; no backpressure (clear wins over train).
module bp_table
  import bp_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int IDX_W = 8,
  parameter int CNT_W = 2
) (
  input  logic                  clk,
  input  logic [IDX_W-1:0]      rd_idx,
  output logic [CNT_W-1:0]      rd_cnt,
  output logic                  rd_vld,
  output logic [XLEN-IDX_W-1:0] rd_tag,
  output logic [XLEN-1:0]       rd_tgt,
  input  logic                  wr_en,
  input  logic [IDX_W-1:0]      wr_idx,
  input  logic                  wr_taken,
  input  logic [XLEN-IDX_W-1:0] wr_tag,
  input  logic [XLEN-1:0]       wr_tgt,
  input  logic                  clr_en,
  input  logic [IDX_W-1:0]      clr_idx
);

  localparam int TAG_W = XLEN - IDX_W;
  localparam int DEPTH = 1 << IDX_W;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(cnt_reset_val(CNT_W));
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  logic [CNT_W-1:0] cnt_q [DEPTH];
  logic             vld_q [DEPTH];
  logic [TAG_W-1:0] tag_q [DEPTH];
  logic [XLEN-1:0]  tgt_q [DEPTH];

  assign rd_cnt = cnt_q[rd_idx];
  assign rd_vld = vld_q[rd_idx];
  assign rd_tag = tag_q[rd_idx];
  assign rd_tgt = tgt_q[rd_idx];

  always_ff @(posedge clk) begin
    if (clr_en) begin
      cnt_q[clr_idx] <= CNT_INIT;
      vld_q[clr_idx] <= 1'b0;
    end else if (wr_en) begin
      if (wr_taken) begin
        if (cnt_q[wr_idx] != CNT_MAX) cnt_q[wr_idx] <= cnt_q[wr_idx] + CNT_W'(1);
        vld_q[wr_idx] <= 1'b1;
        tag_q[wr_idx] <= wr_tag;
        tgt_q[wr_idx] <= wr_tgt;
      end else if (cnt_q[wr_idx] != '0) begin
        cnt_q[wr_idx] <= cnt_q[wr_idx] - CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Fetch-stage direction/target predictor: bimodal or gshare index, speculative GHR, stats, post-reset sweep.
// Predict is 0-cycle combinational; training/repair land at next posedge; no backpressure, ready low while sweeping.
module branch_predictor
  import bp_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int IDX_W  = 8,
  parameter int CNT_W  = 2,
  parameter int MODE   = 0,
  parameter int GHR_W  = 8,
  parameter int STAT_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  output logic              ready,
  input  logic [XLEN-1:0]   pred_pc,
  input  logic              pred_is_branch,
  output logic              pred_taken,
  output logic [XLEN-1:0]   pred_next,
  output logic [GHR_W-1:0]  pred_ghr,
  input  logic              upd_valid,
  input  logic [XLEN-1:0]   upd_pc,
  input  logic [GHR_W-1:0]  upd_ghr,
  input  logic              upd_taken,
  input  logic [XLEN-1:0]   upd_target,
  input  logic              upd_mispredict,
  output logic [STAT_W-1:0] stat_total,
  output logic [STAT_W-1:0] stat_hit,
  output logic [STAT_W-1:0] stat_miss
);

  localparam int TAG_W = XLEN - IDX_W;

  bp_state_t        state;
  logic [IDX_W-1:0] sweep_ptr;
  logic [GHR_W-1:0] ghr;

  logic [IDX_W-1:0] rd_idx, wr_idx;
  logic [CNT_W-1:0] rd_cnt;
  logic             rd_vld;
  logic [TAG_W-1:0] rd_tag;
  logic [XLEN-1:0]  rd_tgt;
  logic             upd_fire;

  assign ready    = (state == RUN);
  assign upd_fire = ready & upd_valid;
  assign pred_ghr = ghr;

  // Predict hashes with the live GHR, training with the snapshot that travelled with the branch.
  generate
    if (MODE == 1) begin : g_gshare
      assign rd_idx = pred_pc[IDX_W-1:0] ^ IDX_W'(ghr);
      assign wr_idx = upd_pc[IDX_W-1:0]  ^ IDX_W'(upd_ghr);
    end else begin : g_bimodal
      assign rd_idx = pred_pc[IDX_W-1:0];
      assign wr_idx = upd_pc[IDX_W-1:0];
    end
  endgenerate

  assign pred_taken = ready & pred_is_branch & rd_cnt[CNT_W-1] & rd_vld
                    & (rd_tag == pred_pc[XLEN-1:IDX_W]);
  assign pred_next  = pred_taken ? rd_tgt : pred_pc + XLEN'(1);

  bp_table #(
    .XLEN  (XLEN),
    .IDX_W (IDX_W),
    .CNT_W (CNT_W)
  ) u_table (
    .clk      (clk),
    .rd_idx   (rd_idx),
    .rd_cnt   (rd_cnt),
    .rd_vld   (rd_vld),
    .rd_tag   (rd_tag),
    .rd_tgt   (rd_tgt),
    .wr_en    (upd_fire & ~rst),
    .wr_idx   (wr_idx),
    .wr_taken (upd_taken),
    .wr_tag   (upd_pc[XLEN-1:IDX_W]),
    .wr_tgt   (upd_target),
    .clr_en   (~ready),
    .clr_idx  (sweep_ptr)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= INIT;
      sweep_ptr  <= '0;
      ghr        <= '0;
      stat_total <= '0;
      stat_hit   <= '0;
      stat_miss  <= '0;
    end else begin
      if (state == INIT) begin
        sweep_ptr <= sweep_ptr + IDX_W'(1);
        if (&sweep_ptr) state <= RUN;
      end
      // Truncating the concatenation keeps the low GHR_W bits, i.e. shift-in on the right.
      if (upd_fire && upd_mispredict) ghr <= GHR_W'({upd_ghr, upd_taken});
      else if (ready && pred_is_branch) ghr <= GHR_W'({ghr, pred_taken});
      if (upd_fire) begin
        stat_total <= stat_total + STAT_W'(1);
        if (upd_mispredict) stat_miss <= stat_miss + STAT_W'(1);
        else                stat_hit  <= stat_hit + STAT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Randomised and directed bench for branch_predictor (gshare, 16 entries) against a table-level reference model.
module tb_branch_predictor;

  localparam int XLEN = 32, IDX_W = 4, CNT_W = 2, MODE = 1, GHR_W = 4, STAT_W = 8;
  localparam int DEPTH = 1 << IDX_W;
  localparam int CMAX = (1 << CNT_W) - 1;
  localparam int CTHR = 1 << (CNT_W - 1);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst = 1'b1;
  logic              ready;
  logic [XLEN-1:0]   pred_pc = '0;
  logic              pred_is_branch = 1'b0;
  logic              pred_taken;
  logic [XLEN-1:0]   pred_next;
  logic [GHR_W-1:0]  pred_ghr;
  logic              upd_valid = 1'b0;
  logic [XLEN-1:0]   upd_pc = '0;
  logic [GHR_W-1:0]  upd_ghr = '0;
  logic              upd_taken = 1'b0;
  logic [XLEN-1:0]   upd_target = '0;
  logic              upd_mispredict = 1'b0;
  logic [STAT_W-1:0] stat_total, stat_hit, stat_miss;

  branch_predictor #(
    .XLEN(XLEN), .IDX_W(IDX_W), .CNT_W(CNT_W), .MODE(MODE), .GHR_W(GHR_W), .STAT_W(STAT_W)
  ) dut (
    .clk(clk), .rst(rst), .ready(ready),
    .pred_pc(pred_pc), .pred_is_branch(pred_is_branch), .pred_taken(pred_taken),
    .pred_next(pred_next), .pred_ghr(pred_ghr),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_ghr(upd_ghr), .upd_taken(upd_taken),
    .upd_target(upd_target), .upd_mispredict(upd_mispredict),
    .stat_total(stat_total), .stat_hit(stat_hit), .stat_miss(stat_miss)
  );

  typedef struct {
    logic        rdy;
    logic        taken;
    logic [31:0] nxt;
    logic [3:0]  ghr;
    logic [7:0]  tot;
    logic [7:0]  hit;
    logic [7:0]  mis;
  } exp_t;

  exp_t sb[$];
  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: one entry per index, plain integers.
  int          m_cnt [DEPTH];
  bit          m_vld [DEPTH];
  int unsigned m_tag [DEPTH];
  int unsigned m_tgt [DEPTH];
  int          m_sweep = 0;
  int unsigned m_ghr = 0, m_tot = 0, m_hit = 0, m_mis = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("ready",      64'(ready),      64'(e.rdy));
        chk("pred_taken", 64'(pred_taken), 64'(e.taken));
        chk("pred_next",  64'(pred_next),  64'(e.nxt));
        chk("pred_ghr",   64'(pred_ghr),   64'(e.ghr));
        chk("stat_total", 64'(stat_total), 64'(e.tot));
        chk("stat_hit",   64'(stat_hit),   64'(e.hit));
        chk("stat_miss",  64'(stat_miss),  64'(e.mis));
      end
    end
  end

  task automatic step(input bit r, input bit br, input logic [31:0] pc,
                      input bit uv, input logic [31:0] upc, input logic [3:0] ug,
                      input bit ut, input logic [31:0] utg, input bit um);
    exp_t e;
    int unsigned idx, ui;
    bit rdy, tk;
    @(posedge clk);
    #1;
    rst = r; pred_is_branch = br; pred_pc = pc;
    upd_valid = uv; upd_pc = upc; upd_ghr = ug; upd_taken = ut;
    upd_target = utg; upd_mispredict = um;

    rdy = (m_sweep == 0);
    idx = (pc ^ m_ghr) % DEPTH;
    tk  = rdy && br && (m_cnt[idx] >= CTHR) && m_vld[idx] && (m_tag[idx] == (pc >> IDX_W));
    if (!r) begin
      e.rdy = rdy; e.taken = tk;
      e.nxt = tk ? m_tgt[idx] : pc + 32'd1;
      e.ghr = m_ghr[3:0];
      e.tot = m_tot[7:0]; e.hit = m_hit[7:0]; e.mis = m_mis[7:0];
      sb.push_back(e);
    end

    if (r) begin
      for (int i = 0; i < DEPTH; i++) begin
        m_cnt[i] = CTHR - 1;
        m_vld[i] = 1'b0;
      end
      m_sweep = DEPTH;
      m_ghr = 0; m_tot = 0; m_hit = 0; m_mis = 0;
    end else if (m_sweep > 0) begin
      m_sweep--;
    end else begin
      if (uv) begin
        ui = (upc ^ ug) % DEPTH;
        if (ut) begin
          if (m_cnt[ui] < CMAX) m_cnt[ui]++;
          m_vld[ui] = 1'b1;
          m_tag[ui] = upc >> IDX_W;
          m_tgt[ui] = utg;
        end else if (m_cnt[ui] > 0) begin
          m_cnt[ui]--;
        end
        m_tot = (m_tot + 1) % 256;
        if (um) m_mis = (m_mis + 1) % 256;
        else    m_hit = (m_hit + 1) % 256;
      end
      if (uv && um)  m_ghr = ((ug << 1) | ut) & 4'hF;
      else if (br)   m_ghr = ((m_ghr << 1) | tk) & 4'hF;
    end
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic predict(input logic [31:0] pc);
    step(0, 1, pc, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic train(input logic [31:0] upc, input logic [3:0] ug, input bit ut,
                       input logic [31:0] utg, input bit um);
    step(0, 0, 0, 1, upc, ug, ut, utg, um);
  endtask

  // PC with the given tag that lands on table entry idx under the model's current history.
  function automatic logic [31:0] pc_for(input int unsigned tag, input int unsigned idx);
    return (tag << IDX_W) | ((idx ^ m_ghr) & (DEPTH - 1));
  endfunction

  task automatic sweep_with_junk();
    repeat (DEPTH) step(0, 1, 32'd5, 1, 32'h12, 4'h0, 1, 32'h99, 1);
  endtask

  initial begin
    logic [31:0] p;
    logic [3:0]  g;

    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    sweep_with_junk();
    predict(32'd5);

    train(32'h12, 4'h0, 1, 32'h40, 0);
    train(32'h12, 4'h0, 1, 32'h40, 0);
    predict(pc_for(32'h1, 2));
    predict(pc_for(32'h11, 2));

    repeat (5) train(32'h23, 4'h0, 1, 32'h80, 0);
    predict(pc_for(32'h2, 3));
    train(32'h23, 4'h0, 0, 32'h0, 0);
    predict(pc_for(32'h2, 3));
    train(32'h23, 4'h0, 0, 32'h0, 0);
    predict(pc_for(32'h2, 3));

    train(32'h77, 4'h0, 0, 32'h0, 1);
    repeat (3) predict(pc_for(32'h1, 2));
    step(0, 1, pc_for(32'h1, 2), 1, 32'h70, 4'b0101, 1, 32'h55, 1);
    idle();

    train(32'h31, 4'h0, 1, 32'h31, 0);
    train(32'h31, 4'h0, 1, 32'h31, 0);
    train(32'h31, 4'h0, 0, 32'h31, 1);
    idle();

    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    sweep_with_junk();
    idle();

    p = pc_for(32'h3, 5);
    g = m_ghr[3:0];
    step(0, 1, p, 1, p, g, 1, 32'hAB, 0);
    predict(pc_for(32'h3, 5));

    repeat (700) begin
      step($urandom_range(0, 499) == 0,
           1'($urandom_range(0, 1)),
           32'($urandom_range(0, 63)),
           $urandom_range(0, 9) < 6,
           32'($urandom_range(0, 63)),
           4'($urandom_range(0, 15)),
           1'($urandom_range(0, 1)),
           $urandom,
           $urandom_range(0, 3) == 0);
    end

    idle();
    @(posedge clk);
    @(negedge clk);
    @(posedge clk);
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
